// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: operand width, RV32M funct3 encodings and
// the multiply/divide sequencer state encoding.
package pipeline_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_e;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit beside the EX-stage ALU: 32-step
// shift-add multiply or restoring divide on magnitudes, sign fixed up at the end.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src0,
    input  logic [XLEN-1:0] src1,
    input  logic            flush,
    output logic            stall_req,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    import pipeline_pkg::*;

    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [5:0]      LAST_CNT = 6'(XLEN - 1);

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    state_e             state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [2*XLEN-1:0]  acc_q, acc_d;
    logic [2*XLEN-1:0]  mcand_q, mcand_d;
    logic [XLEN-1:0]    mplier_q, mplier_d;
    logic [XLEN-1:0]    partRem_q, partRem_d;
    logic [XLEN-1:0]    quot_q, quot_d;
    logic [XLEN-1:0]    divisor_q, divisor_d;
    logic               neg_q, neg_d;
    logic [2:0]         op_q, op_d;
    logic [XLEN-1:0]    stage_q, stage_d;
    logic [XLEN-1:0]    result_q, result_d;

    logic               signed0, signed1, sign0, sign1;
    logic [XLEN-1:0]    abs0, abs1;
    logic               divByZero, divOverflow, accept;
    logic [XLEN:0]      shifted, trial;
    logic [2*XLEN-1:0]  prodFix;

    always_comb begin
        signed0     = (op != OP_MULHU) && (op != OP_DIVU) && (op != OP_REMU);
        signed1     = signed0 && (op != OP_MULHSU);
        sign0       = signed0 && src0[XLEN-1];
        sign1       = signed1 && src1[XLEN-1];
        abs0        = cond_neg(src0, sign0);
        abs1        = cond_neg(src1, sign1);
        divByZero   = (src1 == '0);
        divOverflow = ((op == OP_DIV) || (op == OP_REM)) && (src0 == INT_MIN) && (src1 == '1);
        accept      = (state_q == ST_IDLE) && start && !flush;

        // The 33-bit partial remainder is the old remainder with the next dividend bit shifted in.
        shifted = {partRem_q, quot_q[XLEN-1]};
        trial   = shifted - {1'b0, divisor_q};
        prodFix = neg_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        partRem_d = partRem_q;
        quot_d    = quot_q;
        divisor_d = divisor_q;
        neg_d     = neg_q;
        op_d      = op_q;
        stage_d   = stage_q;
        result_d  = result_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d  = op;
                    cnt_d = '0;
                    if (op[2]) begin
                        neg_d = (op == OP_REM) ? sign0 : (sign0 ^ sign1);
                        if (divByZero) begin
                            stage_d = op[1] ? src0 : '1;
                            state_d = ST_DONE;
                        end else if (divOverflow) begin
                            stage_d = op[1] ? '0 : INT_MIN;
                            state_d = ST_DONE;
                        end else begin
                            partRem_d = '0;
                            quot_d    = abs0;
                            divisor_d = abs1;
                            state_d   = ST_DIV;
                        end
                    end else begin
                        neg_d    = sign0 ^ sign1;
                        acc_d    = '0;
                        mcand_d  = {{XLEN{1'b0}}, abs0};
                        mplier_d = abs1;
                        state_d  = ST_MUL;
                    end
                end
            end
            ST_MUL: begin
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 6'd1;
                if (cnt_q == LAST_CNT) state_d = ST_FIX;
            end
            ST_DIV: begin
                if (!trial[XLEN]) begin
                    partRem_d = trial[XLEN-1:0];
                    quot_d    = {quot_q[XLEN-2:0], 1'b1};
                end else begin
                    partRem_d = shifted[XLEN-1:0];
                    quot_d    = {quot_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_CNT) state_d = ST_FIX;
            end
            ST_FIX: begin
                unique case (op_q)
                    OP_MUL:                       stage_d = prodFix[XLEN-1:0];
                    OP_MULH, OP_MULHSU, OP_MULHU: stage_d = prodFix[2*XLEN-1:XLEN];
                    OP_DIV, OP_DIVU:              stage_d = cond_neg(quot_q, neg_q);
                    default:                      stage_d = cond_neg(partRem_q, neg_q);
                endcase
                state_d = ST_DONE;
            end
            ST_DONE: begin
                // The held result only moves once the DONE cycle completes unflushed.
                if (!flush) result_d = stage_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush && (state_q != ST_IDLE)) state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            partRem_q <= '0;
            quot_q    <= '0;
            divisor_q <= '0;
            neg_q     <= 1'b0;
            op_q      <= '0;
            stage_q   <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            partRem_q <= partRem_d;
            quot_q    <= quot_d;
            divisor_q <= divisor_d;
            neg_q     <= neg_d;
            op_q      <= op_d;
            stage_q   <= stage_d;
            result_q  <= result_d;
        end
    end

    always_comb begin
        stall_req = accept || (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIX);
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE) && !flush;
        result    = done ? stage_q : result_q;
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed RV32M cases, flush/reset interruption and
// random operations, all checked against plain 64-bit arithmetic.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src0;
    logic [31:0] src1;
    logic        flush;
    logic        stall_req;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    muldiv_seq #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .src0      (src0),
        .src1      (src1),
        .flush     (flush),
        .stall_req (stall_req),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    // Architectural RV32M result, including the two divide corner cases.
    function automatic logic [31:0] refModel(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, za, sb, zb, p;
        longint      qa, qb;
        sa = {{32{a[31]}}, a};
        za = {32'b0, a};
        sb = {{32{b[31]}}, b};
        zb = {32'b0, b};
        qa = sa;
        qb = sb;
        p  = '0;
        case (o)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * zb; return p[63:32]; end
            3'd3: begin p = za * zb; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = qa / qb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = za / zb;
                return p[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                p = qa % qb;
                return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = za % zb;
                return p[31:0];
            end
        endcase
    endfunction

    function automatic int refLatency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o[2] && (b == 32'd0)) return 1;
        if (((o == 3'd4) || (o == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
        return 34;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Entered at a negedge; issues one op, follows it to DONE and one cycle past.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] expRes;
        int          expLat;
        int          lat;
        int          stallCnt;
        bit          seen;
        expRes = refModel(o, a, b);
        expLat = refLatency(o, a, b);
        op    = o;
        src0  = a;
        src1  = b;
        start = 1'b1;
        #1 checkOutput("stall_on_issue", {31'b0, stall_req}, 32'd1);
        @(negedge clk);
        start    = 1'b0;
        src0     = $urandom;
        src1     = $urandom;
        lat      = 1;
        stallCnt = 0;
        seen     = 1'b0;
        while (!seen && (lat <= 40)) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (stall_req) stallCnt++;
                lat++;
                @(negedge clk);
            end
        end
        checkOutput("done_seen", {31'b0, seen}, 32'd1);
        if (seen) begin
            checkOutput("done_latency", 32'(lat), 32'(expLat));
            checkOutput("stall_cycles", 32'(stallCnt), 32'(expLat - 1));
            checkOutput("stall_at_done", {31'b0, stall_req}, 32'd0);
            checkOutput("busy_at_done", {31'b0, busy}, 32'd1);
            checkOutput($sformatf("result_op%0d_%h_%h", o, a, b), result, expRes);
            @(negedge clk);
            checkOutput("done_pulse_end", {31'b0, done}, 32'd0);
            checkOutput("busy_after_done", {31'b0, busy}, 32'd0);
            checkOutput("result_held", result, expRes);
        end
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit          sawDone;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = '0;
        src0  = '0;
        src1  = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_done", {31'b0, done}, 32'd0);
        checkOutput("reset_stall", {31'b0, stall_req}, 32'd0);
        checkOutput("reset_result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(3'd0, 32'd7, 32'hFFFF_FFFD);
        applyStimulus(3'd1, 32'h8000_0000, 32'h8000_0000);
        applyStimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        applyStimulus(3'd2, 32'hFFFF_FFFF, 32'd2);
        applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2);
        applyStimulus(3'd6, 32'hFFFF_FFF9, 32'd2);
        applyStimulus(3'd5, 32'd100, 32'd7);
        applyStimulus(3'd7, 32'd100, 32'd7);
        applyStimulus(3'd5, 32'd5, 32'd0);
        applyStimulus(3'd6, 32'd5, 32'd0);
        applyStimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        applyStimulus(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

        // Flush a DIV at T+10, then start a MUL at T+11.
        op      = 3'd4;
        src0    = 32'd1000;
        src1    = 32'd7;
        start   = 1'b1;
        sawDone = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 10; k++) begin
            if (done) sawDone = 1'b1;
            @(negedge clk);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        checkOutput("flush_busy", {31'b0, busy}, 32'd0);
        checkOutput("flush_stall", {31'b0, stall_req}, 32'd0);
        checkOutput("flush_no_done", {31'b0, sawDone | done}, 32'd0);
        applyStimulus(3'd0, 32'd3, 32'd4);

        // Reset at T+5 of a MUL (previous result 12 is nonzero).
        op    = 3'd0;
        src0  = 32'd9;
        src1  = 32'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
        checkOutput("midrst_done", {31'b0, done}, 32'd0);
        checkOutput("midrst_result", result, 32'd0);
        checkOutput("midrst_stall", {31'b0, stall_req}, 32'd0);
        applyStimulus(3'd1, 32'h1234_5678, 32'hFEDC_BA98);

        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = pickOperand();
            rb  = pickOperand();
            applyStimulus(rop, ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
